// File: rtl/counter_datacheck.sv
`default_nettype none
// ============================================================================
//  Module   : counter_datacheck
//  Purpose  : Receive-side checker for the loopback test path. Verifies that
//             returned bytes follow an 8-bit incrementing count (0x00..0xFF,
//             wrapping). Hunts for lock, then counts mismatches while locked
//             and falls back to hunting after a run of consecutive errors.
//  Ports    : clk          - clock
//             reset        - asynchronous, active-high reset
//             rx_valid_i   - rx_data_i holds a byte this cycle
//             rx_data_i    - received byte
//             clear_i      - synchronous clear of err_count/rx_count/lock_lost
//             locked_o     - checker is in the LOCKED state
//             err_pulse_o  - one-cycle strobe per mismatching byte while LOCKED
//             err_count_o  - mismatches while LOCKED, saturating
//             rx_count_o   - valid bytes received, wrapping
//             lock_lost_o  - sticky flag, set on LOCKED->HUNT
//             expected_o   - next byte the checker expects (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module counter_datacheck #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 8,
    parameter int unsigned ERR_W      = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [CNT_W-1:0] rx_count_o,
    output logic             lock_lost_o,
    output logic [7:0]       expected_o
);

    localparam logic [7:0] c_lock_count = 8'(LOCK_COUNT);
    localparam logic [7:0] c_loss_count = 8'(LOSS_COUNT);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [7:0]         expected_q,  expected_d;
    logic [7:0]         run_q,       run_d;
    logic [7:0]         bad_run_q,   bad_run_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   rx_count_q,  rx_count_d;
    logic               lock_lost_q, lock_lost_d;

    logic               w_err_event;
    logic               w_lock_loss;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        run_d       = run_q;
        bad_run_d   = bad_run_q;
        err_pulse_d = 1'b0;
        w_err_event = 1'b0;
        w_lock_loss = 1'b0;

        if (rx_valid_i) begin
            case (state_q)
                ST_HUNT: begin
                    // run == 0 marks the first byte after reset or after
                    // dropping lock; it always starts a fresh candidate run.
                    if ((run_q == 8'd0) || (rx_data_i != expected_q)) begin
                        run_d = 8'd1;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                    // In HUNT the checker resyncs to whatever arrived.
                    expected_d = rx_data_i + 8'd1;
                    if (run_d == c_lock_count) begin
                        state_d   = ST_LOCKED;
                        bad_run_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    // No resync while locked: a single corrupted byte costs
                    // exactly one error instead of two.
                    expected_d = expected_q + 8'd1;
                    if (rx_data_i == expected_q) begin
                        bad_run_d = 8'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        w_err_event = 1'b1;
                        bad_run_d   = bad_run_q + 8'd1;
                        if (bad_run_d == c_loss_count) begin
                            state_d     = ST_HUNT;
                            w_lock_loss = 1'b1;
                            run_d       = 8'd0;
                            bad_run_d   = 8'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        // Statistics: clear wins over any same-cycle increment, but a lock
        // loss coinciding with clear must still be recorded.
        err_count_d = err_count_q;
        rx_count_d  = rx_count_q;
        lock_lost_d = lock_lost_q | w_lock_loss;
        if (clear_i) begin
            err_count_d = '0;
            rx_count_d  = '0;
            lock_lost_d = w_lock_loss;
        end else begin
            if (rx_valid_i) begin
                rx_count_d = rx_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_err_event && (err_count_q != {ERR_W{1'b1}})) begin
                err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            expected_q  <= 8'h00;
            run_q       <= 8'd0;
            bad_run_q   <= 8'd0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            rx_count_q  <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            run_q       <= run_d;
            bad_run_q   <= bad_run_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            rx_count_q  <= rx_count_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign locked_o    = (state_q == ST_LOCKED);
    assign err_pulse_o = err_pulse_q;
    assign err_count_o = err_count_q;
    assign rx_count_o  = rx_count_q;
    assign lock_lost_o = lock_lost_q;
    assign expected_o  = expected_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_datacheck.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_datacheck
//  Purpose  : Self-checking bench for counter_datacheck. Directed scenarios
//             plus a randomized loopback stream, each cycle compared against
//             a behavioural model of the checker's rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_datacheck;

    localparam int LOCK_COUNT = 4;
    localparam int LOSS_COUNT = 8;
    localparam int ERR_W      = 4;
    localparam int CNT_W      = 32;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic             clk;
    logic             reset;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [CNT_W-1:0] rx_count;
    logic             lock_lost;
    logic [7:0]       expected;

    counter_datacheck #(
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_COUNT (LOSS_COUNT),
        .ERR_W      (ERR_W),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .clear_i     (clear),
        .locked_o    (locked),
        .err_pulse_o (err_pulse),
        .err_count_o (err_count),
        .rx_count_o  (rx_count),
        .lock_lost_o (lock_lost),
        .expected_o  (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int n_pulse;

    // Behavioural model state
    bit          m_locked;
    int          m_exp;
    int          m_run;       // 0 = no byte yet since entering hunt
    int          m_bad;
    int          m_err;
    logic [31:0] m_rx;
    bit          m_lost;
    bit          m_pulse;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_exp = 0; m_run = 0; m_bad = 0;
        m_err = 0; m_rx = '0; m_lost = 0; m_pulse = 0;
    endtask

    task automatic model_apply(input bit v, input int d, input bit clr);
        bit lost_now;
        bit err_now;
        lost_now = 0;
        err_now  = 0;
        m_pulse  = 0;
        if (v) begin
            if (!m_locked) begin
                m_run = (m_run != 0 && d == m_exp) ? m_run + 1 : 1;
                m_exp = (d + 1) % 256;
                if (m_run >= LOCK_COUNT) begin
                    m_locked = 1;
                    m_bad    = 0;
                end
            end else begin
                if (d == m_exp) begin
                    m_bad = 0;
                end else begin
                    m_pulse = 1;
                    err_now = 1;
                    m_bad   = m_bad + 1;
                    if (m_bad >= LOSS_COUNT) begin
                        m_locked = 0;
                        lost_now = 1;
                        m_run    = 0;
                        m_bad    = 0;
                    end
                end
                m_exp = (m_exp + 1) % 256;
            end
        end
        if (clr) begin
            m_err  = 0;
            m_rx   = '0;
            m_lost = lost_now;
        end else begin
            if (v) m_rx = m_rx + 32'd1;
            if (err_now && m_err < ERR_MAX) m_err = m_err + 1;
            if (lost_now) m_lost = 1;
        end
    endtask

    task automatic check_model();
        check("locked",    locked,    m_locked);
        check("err_pulse", err_pulse, m_pulse);
        check("err_count", err_count, m_err);
        check("rx_count",  rx_count,  m_rx);
        check("lock_lost", lock_lost, m_lost);
        check("expected",  expected,  m_exp);
    endtask

    // One clock: drive, sample edge, advance model, compare #1 later.
    task automatic step(input bit v, input logic [7:0] d, input bit clr);
        rx_valid = v;
        rx_data  = d;
        clear    = clr;
        @(posedge clk);
        model_apply(v, int'(d), clr);
        #1;
        check_model();
        if (err_pulse === 1'b1) n_pulse++;
        rx_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_locked",    locked,    1'b0);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_err_count", err_count, '0);
        check("rst_rx_count",  rx_count,  '0);
        check("rst_lock_lost", lock_lost, 1'b0);
        check("rst_expected",  expected,  8'h00);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] acq [6];
        logic [7:0] gen;
        int burst;

        acq[0] = 8'hFC; acq[1] = 8'hFD; acq[2] = 8'hFE;
        acq[3] = 8'hFF; acq[4] = 8'h00; acq[5] = 8'h01;

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        reset = 1'b0;

        // Acquisition across the 0xFF -> 0x00 wrap
        n_pulse = 0;
        for (int i = 0; i < 6; i++) begin
            send(acq[i]);
            if (i == 2) check("acq_not_yet_locked", locked, 1'b0);
            if (i == 3) check("acq_locked_after_ff", locked, 1'b1);
        end
        check("acq_expected", expected, 8'h02);
        check("acq_rx_count", rx_count, 32'd6);
        check("acq_err_count", err_count, 4'd0);
        check("acq_no_pulse", n_pulse, 0);

        // Single corruption at expected = 0x10
        for (int b = 2; b < 16; b++) send(8'(b));
        check("sc_expected_start", expected, 8'h10);
        n_pulse = 0;
        send(8'h10); send(8'h55); send(8'h12); send(8'h13);
        check("sc_pulses", n_pulse, 1);
        check("sc_err_count", err_count, 4'd1);
        check("sc_locked", locked, 1'b1);
        check("sc_expected", expected, 8'h14);

        // Loss of lock after 8 consecutive errors
        step(1'b0, 8'h00, 1'b1);
        n_pulse = 0;
        for (int i = 0; i < 8; i++) begin
            send(8'hAA);
            if (i == 6) check("loss_still_locked", locked, 1'b1);
        end
        check("loss_pulses", n_pulse, 8);
        check("loss_unlocked", locked, 1'b0);
        check("loss_sticky", lock_lost, 1'b1);
        check("loss_err_count", err_count, 4'd8);
        for (int i = 0; i < 4; i++) begin
            send(8'(8'h30 + i));
            step(1'b0, 8'h00, 1'b0);
        end
        check("relock", locked, 1'b1);
        check("relock_err_count", err_count, 4'd8);

        // Gaps plus 20 isolated mismatches: saturation at 0xF
        for (int i = 0; i < 20; i++) begin
            send(expected);
            step(1'b0, 8'h00, 1'b0);
            send(8'(expected + 8'd1 + 8'($urandom_range(0, 254))));
            step(1'b0, 8'h00, 1'b0);
        end
        check("sat_err_count", err_count, 4'hF);
        check("sat_locked", locked, 1'b1);

        // Clear together with a mismatching byte
        step(1'b1, 8'(expected + 8'd3), 1'b1);
        check("clr_err_count", err_count, 4'd0);
        check("clr_rx_count", rx_count, 32'd0);
        check("clr_lock_lost", lock_lost, 1'b0);
        check("clr_locked", locked, 1'b1);

        // Reset mid-stream, then reacquire with 4 in-sequence bytes
        send(expected);
        async_reset();
        for (int i = 0; i < 4; i++) begin
            send(8'(8'h80 + i));
            if (i == 2) check("rr_not_locked", locked, 1'b0);
        end
        check("rr_locked", locked, 1'b1);

        // Randomized loopback stream: gaps, corruptions, bursts, resyncs, clears
        gen   = 8'($urandom);
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit clr;
            logic [7:0] d;
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 99) < 2);
            d   = gen;
            if (v) begin
                if (burst > 0) begin
                    d = 8'(gen + 8'd1 + 8'($urandom_range(0, 254)));
                    burst--;
                end else begin
                    int r;
                    r = $urandom_range(0, 99);
                    if (r < 4) begin
                        burst = $urandom_range(1, 10);
                    end else if (r < 7) begin
                        gen = 8'($urandom);
                        d   = gen;
                    end else if (r < 12) begin
                        d = 8'(gen + 8'd1 + 8'($urandom_range(0, 254)));
                    end
                end
                gen = gen + 8'd1;
            end
            step(v, d, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
